pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_pkg.sv | 24 ++
 rtl/pc_adder.sv | 18 +
 rtl/pc_unit.sv | 183 ++++++++++++++++++
 tb/tb_pc_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the program counter unit
//
// Purpose: FSM state encoding, next-PC source selector and the sequential
//          PC increment used by pc_unit.
// Ports:   none (package).

package pc_pkg;

    localparam int PC_INC = 4;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_JUMP   = 2'd1,
        SEL_BRANCH = 2'd2,
        SEL_PLUS4  = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/pc_adder.sv
// rtl/pc_adder.sv - modulo 2^width adder for the branch target
//
// Purpose: adds the branch offset to pc+4; carry out is discarded so the
//          result wraps naturally.
// Ports:   i_a, i_b - operands (width bits)
//          o_sum    - (i_a + i_b) mod 2^width

module pc_adder #(
    parameter int width = 32
) (
    input  logic [width-1:0] i_a,
    input  logic [width-1:0] i_b,
    output logic [width-1:0] o_sum
);

    assign o_sum = i_a + i_b;

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with fetch handshake, branch/jump and halt
//
// Purpose: holds the fetch PC, advances it when instruction memory returns a
//          word, selects jump/branch/sequential targets and tracks status.
// Ports:   clk, rst            - clock, synchronous active-high reset
//          imem_ready          - fetch word for pc is available this cycle
//          branch_taken/offset - taken branch and its byte offset
//          jump/jump_index     - J-type instruction and its 26-bit index
//          halt_req            - stop fetching (sticky until reset)
//          pc, pc_plus4        - current PC and its sequential successor
//          advance             - pc loads a new value at the next edge
//          stall, halted       - FSM in WAIT / HALT
//          redirect            - last update took a jump or branch target
//          misalign            - sticky: a taken branch had offset[1:0] != 0
//          instr_count         - number of advances since reset

module pc_unit
    import pc_pkg::*;
#(
    parameter int               width    = 32,
    parameter logic [width-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_ready,
    input  logic             branch_taken,
    input  logic [width-1:0] branch_offset,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             halt_req,
    output logic [width-1:0] pc,
    output logic [width-1:0] pc_plus4,
    output logic             advance,
    output logic             stall,
    output logic             halted,
    output logic             redirect,
    output logic             misalign,
    output logic [31:0]      instr_count
);

    pc_state_t        r_state;
    pc_state_t        w_state_nxt;
    pc_sel_t          w_sel;

    logic [width-1:0] r_pc;
    logic             r_redirect;
    logic             r_misalign;
    logic [31:0]      r_instr_count;

    logic [width-1:0] w_pc_plus4;
    logic [width-1:0] w_jump_target;
    logic [width-1:0] w_branch_sum;
    logic [width-1:0] w_branch_target;
    logic [width-1:0] w_pc_nxt;
    logic             w_advance;
    logic             w_stall;
    logic             w_halted;
    logic             w_redirect_sel;

    // ---------------- target computation ----------------
    assign w_pc_plus4    = r_pc + width'(PC_INC);
    assign w_jump_target = {w_pc_plus4[width-1:28], jump_index, 2'b00};

    pc_adder #(
        .width (width)
    ) u_branch_adder (
        .i_a   (w_pc_plus4),
        .i_b   (branch_offset),
        .o_sum (w_branch_sum)
    );

    // Word-align the branch target; a misaligned offset is reported, not trapped.
    assign w_branch_target = w_branch_sum & {{(width-2){1'b1}}, 2'b00};

    // halt_req outranks everything, then jump over branch.
    always_comb begin
        w_sel = SEL_PLUS4;
        if (halt_req) begin
            w_sel = SEL_HOLD;
        end else if (jump) begin
            w_sel = SEL_JUMP;
        end else if (branch_taken) begin
            w_sel = SEL_BRANCH;
        end
    end

    always_comb begin
        w_pc_nxt = w_pc_plus4;
        case (w_sel)
            SEL_HOLD:   w_pc_nxt = r_pc;
            SEL_JUMP:   w_pc_nxt = w_jump_target;
            SEL_BRANCH: w_pc_nxt = w_branch_target;
            SEL_PLUS4:  w_pc_nxt = w_pc_plus4;
            default:    w_pc_nxt = w_pc_plus4;
        endcase
    end

    assign w_redirect_sel = (w_sel == SEL_JUMP) || (w_sel == SEL_BRANCH);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (halt_req) begin
                    w_state_nxt = HALT;
                end else if (!imem_ready) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (halt_req) begin
                    w_state_nxt = HALT;
                end else if (imem_ready) begin
                    w_state_nxt = RUN;
                end
            end
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = RUN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // rst gates advance so a reset cycle never counts as a fetch.
    always_comb begin
        w_advance = 1'b0;
        w_stall   = 1'b0;
        w_halted  = 1'b0;
        case (r_state)
            RUN: begin
                w_advance = imem_ready && !halt_req && !rst;
            end
            WAIT: begin
                w_advance = imem_ready && !halt_req && !rst;
                w_stall   = 1'b1;
            end
            HALT: begin
                w_halted  = 1'b1;
            end
            default: begin
                w_advance = 1'b0;
            end
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_redirect    <= 1'b0;
            r_misalign    <= 1'b0;
            r_instr_count <= 32'd0;
        end else begin
            r_redirect <= w_advance && w_redirect_sel;
            if (w_advance) begin
                r_pc          <= w_pc_nxt;
                r_instr_count <= r_instr_count + 32'd1;
                if ((w_sel == SEL_BRANCH) && (branch_offset[1:0] != 2'b00)) begin
                    r_misalign <= 1'b1;
                end
            end
        end
    end

    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign advance     = w_advance;
    assign stall       = w_stall;
    assign halted      = w_halted;
    assign redirect    = r_redirect;
    assign misalign    = r_misalign;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit

module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ready;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        halt_req;

    logic [31:0] pc, pc_plus4, instr_count;
    logic        advance, stall, halted, redirect, misalign;

    logic [31:0] pc_b, pc_plus4_b, instr_count_b;
    logic        advance_b, stall_b, halted_b, redirect_b, misalign_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_unit #(.width(32), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_ready    (imem_ready),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .halt_req      (halt_req),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .advance       (advance),
        .stall         (stall),
        .halted        (halted),
        .redirect      (redirect),
        .misalign      (misalign),
        .instr_count   (instr_count)
    );

    pc_unit #(.width(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk           (clk),
        .rst           (rst),
        .imem_ready    (imem_ready),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .halt_req      (halt_req),
        .pc            (pc_b),
        .pc_plus4      (pc_plus4_b),
        .advance       (advance_b),
        .stall         (stall_b),
        .halted        (halted_b),
        .redirect      (redirect_b),
        .misalign      (misalign_b),
        .instr_count   (instr_count_b)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        br;
        logic [31:0] off;
        logic        jmp;
        logic [25:0] idx;
        logic        hlt;
        logic        exp_adv;
        logic [31:0] exp_pc;
        logic        exp_red;
        logic        exp_mis;
        logic [31:0] exp_cnt;
        logic        exp_stall;
        logic        exp_halt;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic add(input logic r, input logic rdy, input logic br, input logic [31:0] off,
                       input logic jmp, input logic [25:0] idx, input logic hlt,
                       input logic adv, input logic [31:0] epc, input logic red, input logic mis,
                       input logic [31:0] cnt, input logic stl, input logic hal);
        vec_t v;
        v.rst = r;  v.rdy = rdy; v.br = br; v.off = off; v.jmp = jmp; v.idx = idx; v.hlt = hlt;
        v.exp_adv = adv; v.exp_pc = epc; v.exp_red = red; v.exp_mis = mis;
        v.exp_cnt = cnt; v.exp_stall = stl; v.exp_halt = hal;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        rst = 1'b1; imem_ready = 1'b0; branch_taken = 1'b0; branch_offset = '0;
        jump = 1'b0; jump_index = '0; halt_req = 1'b0;

        //   rst rdy br off            jmp idx       hlt  adv pc             red mis cnt stl hal
        add(1, 0, 0, 32'h0,          0, 26'h0,   0,   0, 32'h0,          0, 0, 0,  0, 0);
        add(0, 1, 0, 32'h0,          0, 26'h0,   0,   1, 32'h4,          0, 0, 1,  0, 0);
        add(0, 1, 0, 32'h0,          0, 26'h0,   0,   1, 32'h8,          0, 0, 2,  0, 0);
        add(0, 0, 0, 32'h0,          0, 26'h0,   0,   0, 32'h8,          0, 0, 2,  1, 0);
        add(0, 0, 0, 32'h0,          0, 26'h0,   0,   0, 32'h8,          0, 0, 2,  1, 0);
        add(0, 1, 0, 32'h0,          0, 26'h0,   0,   1, 32'hC,          0, 0, 3,  0, 0);
        add(0, 1, 0, 32'h0,          0, 26'h0,   0,   1, 32'h10,         0, 0, 4,  0, 0);
        add(0, 1, 1, 32'hC,          0, 26'h0,   0,   1, 32'h20,         1, 0, 5,  0, 0);
        add(0, 1, 0, 32'h0,          0, 26'h0,   0,   1, 32'h24,         0, 0, 6,  0, 0);
        add(0, 1, 1, 32'h1000_0018,  0, 26'h0,   0,   1, 32'h1000_0040,  1, 0, 7,  0, 0);
        add(0, 1, 0, 32'h0,          1, 26'h100, 0,   1, 32'h1000_0400,  1, 0, 8,  0, 0);
        add(0, 1, 1, 32'hFFFF_FC3C,  0, 26'h0,   0,   1, 32'h1000_0040,  1, 0, 9,  0, 0);
        add(0, 1, 1, 32'h6,          1, 26'h100, 0,   1, 32'h1000_0400,  1, 0, 10, 0, 0);
        add(0, 1, 0, 32'h0,          0, 26'h0,   0,   1, 32'h1000_0404,  0, 0, 11, 0, 0);
        add(0, 1, 0, 32'h0,          0, 26'h0,   1,   0, 32'h1000_0404,  0, 0, 11, 0, 1);
        add(1, 1, 0, 32'h0,          0, 26'h0,   1,   0, 32'h0,          0, 0, 0,  0, 0);
        add(0, 1, 1, 32'h6,          0, 26'h0,   0,   1, 32'h8,          1, 1, 1,  0, 0);
        add(0, 1, 0, 32'h0,          0, 26'h0,   0,   1, 32'hC,          0, 1, 2,  0, 0);
        add(0, 1, 0, 32'h0,          0, 26'h0,   0,   1, 32'h10,         0, 1, 3,  0, 0);
        add(0, 1, 0, 32'h0,          0, 26'h0,   0,   1, 32'h14,         0, 1, 4,  0, 0);
        add(0, 0, 0, 32'h0,          0, 26'h0,   1,   0, 32'h14,         0, 1, 4,  0, 1);
        for (int k = 0; k < 5; k++)
            add(0, 1, 0, 32'h0,      1, 26'h3,   0,   0, 32'h14,         0, 1, 4,  0, 1);
        add(1, 0, 0, 32'h0,          0, 26'h0,   0,   0, 32'h0,          0, 0, 0,  0, 0);
        add(0, 0, 0, 32'h0,          0, 26'h0,   0,   0, 32'h0,          0, 0, 0,  1, 0);
        add(1, 0, 0, 32'h0,          0, 26'h0,   0,   0, 32'h0,          0, 0, 0,  0, 0);
        add(0, 1, 0, 32'h0,          0, 26'h0,   0,   1, 32'h4,          0, 0, 1,  0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst           = vecs[i].rst;
            imem_ready    = vecs[i].rdy;
            branch_taken  = vecs[i].br;
            branch_offset = vecs[i].off;
            jump          = vecs[i].jmp;
            jump_index    = vecs[i].idx;
            halt_req      = vecs[i].hlt;
            #1;
            chk("advance", i, {31'd0, advance}, {31'd0, vecs[i].exp_adv});
            sb.push_back(vecs[i]);
            @(posedge clk);
            #2;
            e = sb.pop_front();
            chk("pc",          i, pc,          e.exp_pc);
            chk("pc_plus4",    i, pc_plus4,    e.exp_pc + 32'd4);
            chk("redirect",    i, {31'd0, redirect}, {31'd0, e.exp_red});
            chk("misalign",    i, {31'd0, misalign}, {31'd0, e.exp_mis});
            chk("instr_count", i, instr_count, e.exp_cnt);
            chk("stall",       i, {31'd0, stall},    {31'd0, e.exp_stall});
            chk("halted",      i, {31'd0, halted},   {31'd0, e.exp_halt});
        end

        // RESET_PC at the top of the address space wraps to 0 on one advance.
        rst = 1'b1; imem_ready = 1'b0; branch_taken = 1'b0; jump = 1'b0; halt_req = 1'b0;
        @(posedge clk);
        #2;
        chk("wrap_reset_pc",    100, pc_b,          32'hFFFF_FFFC);
        chk("wrap_pc_plus4",    100, pc_plus4_b,    32'h0);
        chk("wrap_count_reset", 100, instr_count_b, 32'h0);
        rst = 1'b0; imem_ready = 1'b1;
        #1;
        chk("wrap_advance",     101, {31'd0, advance_b}, 32'd1);
        @(posedge clk);
        #2;
        chk("wrap_pc",          101, pc_b,          32'h0);
        chk("wrap_count",       101, instr_count_b, 32'h1);
        chk("wrap_redirect",    101, {31'd0, redirect_b}, 32'd0);
        chk("base_pc",          101, pc,            32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
